// File: rtl/led_pattern_gen_pkg.sv
// led_pattern_gen shared types and defaults
// mode encoding, parameter defaults, helpers
package led_pattern_pkg;

   typedef enum logic [1:0] {
      MODE_UP      = 2'b00,
      MODE_DOWN    = 2'b01,
      MODE_BOUNCE  = 2'b10,
      MODE_BREATHE = 2'b11
   } mode_e;

   localparam int LED_CNT_DEF  = 10;
   localparam int DIV_DEF      = 20_000;
   localparam int PWM_BITS_DEF = 4;

   // counter width able to hold div (min 1)
   function automatic int cnt_w(input int div);
      return (div < 1) ? 1 : $clog2(div + 1);
   endfunction

endpackage

// File: rtl/led_pattern_gen_if.sv
// led_pattern_gen control/LED bundle
// master drives controls, slave drives LEDs
interface led_pattern_if
   import led_pattern_pkg::*;
#(
   parameter int LED_CNT = LED_CNT_DEF
) ();

   logic               run_i;
   logic               step_i;
   logic [1:0]         mode_i;
   logic [LED_CNT-1:0] leds_o;
   logic               tick_o;

   modport master (
      output run_i,
      output step_i,
      output mode_i,
      input  leds_o,
      input  tick_o
   );

   modport slave (
      input  run_i,
      input  step_i,
      input  mode_i,
      output leds_o,
      output tick_o
   );

endinterface

// File: rtl/led_pattern_gen_div.sv
// clk_enable_div: prescaler, tick every DIV+1
// enabled clocks; holds when disabled
module clk_enable_div
   import led_pattern_pkg::*;
#(
   parameter int DIV = DIV_DEF
) (
   input  logic CLK_50,
   input  logic rst,
   input  logic ena,
   input  logic reload,
   output logic tick
);

   localparam int CW = cnt_w(DIV);
   localparam logic [CW-1:0] LOAD = CW'(DIV);

   logic [CW-1:0] cnt;

   assign tick = ena & ~reload & (cnt == '0);

   // down-count while enabled, reload at zero
   always_ff @(posedge CLK_50) begin
      if (rst || reload) begin
         cnt <= LOAD;
      end else if (ena) begin
         if (cnt == '0)
            cnt <= LOAD;
         else
            cnt <= cnt - CW'(1);
      end
   end

endmodule

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: count/bounce/breathe LEDs
// advanced by prescaler ticks or manual steps
module led_pattern_gen
   import led_pattern_pkg::*;
#(
   parameter int LED_CNT  = LED_CNT_DEF,
   parameter int DIV      = DIV_DEF,
   parameter int PWM_BITS = PWM_BITS_DEF
) (
   input  logic CLK_50,
   input  logic rst,
   led_pattern_if.slave bus
);

   localparam int PW = $clog2(LED_CNT);
   localparam int DMAX = (2 ** PWM_BITS) - 1;

   localparam logic [PW-1:0] POS_MAX =
      PW'(LED_CNT - 1);
   localparam logic [PWM_BITS-1:0] DUTY_MAX =
      PWM_BITS'(DMAX);
   localparam logic [LED_CNT-1:0] ONE =
      LED_CNT'(1);

   mode_e mode_i;
   mode_e mode_q;

   logic step_q;
   logic tick;
   logic rise;
   logic adv;
   logic mode_chg;

   logic [LED_CNT-1:0]  pattern;
   logic [PW-1:0]       pos;
   logic                dir;
   logic [PWM_BITS-1:0] duty;
   logic                ddir;
   logic [PWM_BITS-1:0] pwm_cnt;

   logic [LED_CNT-1:0]  onehot;
   logic [LED_CNT-1:0]  leds_d;

   assign mode_i   = mode_e'(bus.mode_i);
   assign mode_chg = (mode_i != mode_q);
   assign rise     = bus.step_i & ~step_q;
   assign adv      = ~mode_chg &
                     (bus.run_i ? tick : rise);
   assign onehot   = ONE << pos;

   clk_enable_div #(
      .DIV (DIV)
   ) u_div (
      .CLK_50 (CLK_50),
      .rst    (rst),
      .ena    (bus.run_i),
      .reload (mode_chg),
      .tick   (tick)
   );

   // pattern state, step edge and pwm counter
   always_ff @(posedge CLK_50) begin
      if (rst) begin
         mode_q  <= mode_i;
         step_q  <= 1'b0;
         pwm_cnt <= '0;
         pattern <= '0;
         pos     <= '0;
         dir     <= 1'b1;
         duty    <= '0;
         ddir    <= 1'b1;
      end else begin
         mode_q  <= mode_i;
         step_q  <= bus.step_i;
         pwm_cnt <= pwm_cnt + PWM_BITS'(1);
         if (mode_chg) begin
            pattern <= '0;
            pos     <= '0;
            dir     <= 1'b1;
            duty    <= '0;
            ddir    <= 1'b1;
         end else if (adv) begin
            unique case (mode_q)
               MODE_UP:
                  pattern <= pattern + LED_CNT'(1);
               MODE_DOWN:
                  pattern <= pattern - LED_CNT'(1);
               MODE_BOUNCE: begin
                  if (dir) begin
                     if (pos == POS_MAX) begin
                        pos <= pos - PW'(1);
                        dir <= 1'b0;
                     end else begin
                        pos <= pos + PW'(1);
                     end
                  end else begin
                     if (pos == '0) begin
                        pos <= PW'(1);
                        dir <= 1'b1;
                     end else begin
                        pos <= pos - PW'(1);
                     end
                  end
               end
               MODE_BREATHE: begin
                  if (ddir) begin
                     if (duty == DUTY_MAX) begin
                        duty <= duty - PWM_BITS'(1);
                        ddir <= 1'b0;
                     end else begin
                        duty <= duty + PWM_BITS'(1);
                     end
                  end else begin
                     if (duty == '0) begin
                        duty <= PWM_BITS'(1);
                        ddir <= 1'b1;
                     end else begin
                        duty <= duty - PWM_BITS'(1);
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // select LED image for the current mode
   always_comb begin
      leds_d = '0;
      unique case (mode_q)
         MODE_UP,
         MODE_DOWN:    leds_d = pattern;
         MODE_BOUNCE:  leds_d = onehot;
         MODE_BREATHE: leds_d =
            {LED_CNT{pwm_cnt < duty}};
         default:      leds_d = '0;
      endcase
   end

   // registered LED and tick outputs
   always_ff @(posedge CLK_50) begin
      if (rst) begin
         bus.leds_o <= '0;
         bus.tick_o <= 1'b0;
      end else begin
         bus.leds_o <= leds_d;
         bus.tick_o <= tick;
      end
   end

endmodule
